// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if: three-wire SIO bus between a TM1638 master and the responder.
// sio_clk/sio_stb/dio_in are driven by the master; dio_out/dio_oe by the responder.
interface tm1638_responder_if;
  logic sio_clk;
  logic sio_stb;
  logic dio_in;
  logic dio_out;
  logic dio_oe;
  modport master (output sio_clk, sio_stb, dio_in, input dio_out, dio_oe);
  modport slave (input sio_clk, sio_stb, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 slave model, decodes SIO commands, holds display RAM, returns key bytes.
// Ports: clk, rst_n (async active-low); bus (SIO slave side); keys_in (1 = pressed);
// disp_ram (byte a at [a*8+:8]); leds (odd-byte bit 0, reversed); disp_on, brightness.
module tm1638_responder #(
  parameter int CLK_MHZ = 50
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tm1638_responder_if.slave    bus,
  input  logic [7:0]           keys_in,
  output logic [127:0]         disp_ram,
  output logic [7:0]           leds,
  output logic                 disp_on,
  output logic [2:0]           brightness
);
  typedef enum logic [1:0] {CMD, DATA, READ, IGNORE} phase_t;
  phase_t phase, phase_n;
  logic [2:0] ck_r, sb_r;
  logic [1:0] di_r;
  logic [7:0] shreg, rbyte;
  logic [2:0] cnt, kidx, kn;
  logic [3:0] addr;
  logic done, active, oe, fixed;
  logic rise, fall, stb_fall, stb_rise;
  // Key byte k: bit0 = keys[7-k], bit4 = keys[3-k]; k >= 4 reads as zero.
  function automatic logic [7:0] kb(input logic [2:0] k, input logic [7:0] keys);
    return k[2] ? 8'h00 : {3'b0, keys[{1'b0, ~k[1:0]}], 3'b0, keys[{1'b1, ~k[1:0]}]};
  endfunction
  // Clock edges only count inside a frame; active still holds in the cycle stb rise is seen,
  // so a last bit coinciding with frame end is still taken.
  assign rise = active & ck_r[1] & ~ck_r[2];
  assign fall = active & ~ck_r[1] & ck_r[2];
  assign stb_fall = ~sb_r[1] & sb_r[2];
  assign stb_rise = sb_r[1] & ~sb_r[2];
  assign kn = kidx[2] ? kidx : kidx + 3'd1;
  assign bus.dio_out = (phase == READ) & rbyte[cnt];
  assign bus.dio_oe = oe;
  always_comb begin
    phase_n = phase;
    if (done && phase == CMD)
      phase_n = shreg[7:6] == 2'b01 ? (shreg[1] ? READ : IGNORE) :
                shreg[7:6] == 2'b11 ? DATA : IGNORE;
    if (stb_fall) phase_n = CMD;
  end
  always_comb begin
    leds = '0;
    for (int j = 0; j < 8; j++) leds[7-j] = disp_ram[16*j+8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= CMD;
    else phase <= phase_n;
  // Synchronisers reset low so a strobe held low through reset release never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ck_r <= '0;
      sb_r <= '0;
      di_r <= '0;
      shreg <= '0;
      rbyte <= '0;
      cnt <= '0;
      kidx <= '0;
      addr <= '0;
      done <= 1'b0;
      active <= 1'b0;
      oe <= 1'b0;
      fixed <= 1'b0;
      disp_ram <= '0;
      disp_on <= 1'b0;
      brightness <= '0;
    end else begin
      ck_r <= {ck_r[1:0], bus.sio_clk};
      sb_r <= {sb_r[1:0], bus.sio_stb};
      di_r <= {di_r[0], bus.dio_in};
      done <= rise && cnt == 3'd7;
      if (stb_fall) begin
        cnt <= '0;
        kidx <= '0;
        active <= 1'b1;
      end
      if (rise) begin
        shreg <= {di_r[1], shreg[7:1]};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7 && phase == READ) begin
          rbyte <= kb(kn, keys_in);
          kidx <= kn;
        end
      end
      if (done) begin
        if (phase == CMD && shreg[7:6] == 2'b01) begin
          fixed <= shreg[2];
          rbyte <= kb(3'd0, keys_in);
        end
        if (phase == CMD && shreg[7:6] == 2'b11) addr <= shreg[3:0];
        if (phase == CMD && shreg[7:6] == 2'b10) begin
          disp_on <= shreg[3];
          brightness <= shreg[2:0];
        end
        if (phase == DATA) begin
          disp_ram[{addr, 3'b0} +: 8] <= shreg;
          addr <= addr + {3'b0, ~fixed};
        end
      end
      if (fall && phase == READ) oe <= 1'b1;
      if (stb_rise) begin
        active <= 1'b0;
        oe <= 1'b0;
      end
    end
endmodule
